// File: rtl/branch_pkg.sv
// Shared definitions for the branch/jump PC sequencer: op codes, FSM states
// and the displacement sign-extension helper.
package branch_pkg;

    localparam int DEFAULT_OFFSET_W = 19;

    typedef enum logic [1:0] {
        OP_BR  = 2'b00,
        OP_JR  = 2'b01,
        OP_JAL = 2'b10,
        OP_RSV = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        CON_REQ,
        CON_WAIT,
        EVAL
    } state_e;

    // Sign-extend the low 'width' bits of raw to 32 bits; width is a
    // constant at every call site, so this reduces to plain wiring.
    function automatic logic [31:0] sign_ext(input logic [31:0] raw, input int width);
        logic signed [31:0] tmp;
        tmp = $signed(raw << (32 - width));
        return $unsigned(tmp >>> (32 - width));
    endfunction

endpackage

// File: rtl/branch_pc_unit_pc_reg.sv
// 32-bit program counter register with load and increment controls.
module pc_reg #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        clr_n,
    input  logic        inc_en,
    input  logic        load_en,
    input  logic [31:0] load_val,
    output logic [31:0] pc
);

    // A load wins over an increment so jumps override a concurrent fetch.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            pc <= RESET_PC;
        end else if (load_en) begin
            pc <= load_val;
        end else if (inc_en) begin
            pc <= pc + 32'd1;
        end
    end

endmodule

// File: rtl/branch_pc_unit.sv
// Program counter owner and branch/jump sequencer; talks to the CON
// condition flip-flop for conditional branches.
module branch_pc_unit
    import branch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          OFFSET_W = DEFAULT_OFFSET_W
) (
    input  logic        clk,
    input  logic        clr_n,
    input  logic        fetch_inc,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] ir,
    input  logic [31:0] ra_value,
    input  logic        con_in,
    output logic        con_load,
    output logic [31:0] pc,
    output logic        link_we,
    output logic [31:0] link_data,
    output logic        busy,
    output logic        done,
    output logic        taken,
    output logic        illegal
);

    state_e      state;
    state_e      state_next;
    logic [31:0] off_q;
    logic [31:0] off_next;
    logic        pc_inc;
    logic        pc_load;
    logic [31:0] pc_load_val;
    logic [31:0] pc_plus1;
    logic        con_load_next;
    logic        link_we_next;
    logic [31:0] link_data_next;
    logic        done_next;
    logic        taken_next;
    logic        illegal_next;

    assign pc_plus1 = pc + 32'd1;
    assign busy     = (state != IDLE);

    pc_reg #(
        .RESET_PC(RESET_PC)
    ) u_pc_reg (
        .clk      (clk),
        .clr_n    (clr_n),
        .inc_en   (pc_inc),
        .load_en  (pc_load),
        .load_val (pc_load_val),
        .pc       (pc)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, PC control and next values of the registered strobes.
    always_comb begin
        state_next     = state;
        off_next       = off_q;
        pc_inc         = 1'b0;
        pc_load        = 1'b0;
        pc_load_val    = pc;
        con_load_next  = 1'b0;
        link_we_next   = 1'b0;
        link_data_next = link_data;
        done_next      = 1'b0;
        taken_next     = 1'b0;
        illegal_next   = 1'b0;
        case (state)
            IDLE: begin
                pc_inc = fetch_inc;
                if (start) begin
                    case (op)
                        OP_BR: begin
                            off_next      = sign_ext(ir, OFFSET_W);
                            con_load_next = 1'b1;
                            state_next    = CON_REQ;
                        end
                        OP_JR: begin
                            pc_load     = 1'b1;
                            pc_load_val = ra_value;
                            done_next   = 1'b1;
                            taken_next  = 1'b1;
                        end
                        OP_JAL: begin
                            pc_load        = 1'b1;
                            pc_load_val    = ra_value;
                            link_we_next   = 1'b1;
                            link_data_next = fetch_inc ? pc_plus1 : pc;
                            done_next      = 1'b1;
                            taken_next     = 1'b1;
                        end
                        default: begin
                            illegal_next = 1'b1;
                        end
                    endcase
                end
            end
            CON_REQ: begin
                state_next = CON_WAIT;
            end
            CON_WAIT: begin
                state_next = EVAL;
            end
            EVAL: begin
                if (con_in) begin
                    pc_load     = 1'b1;
                    pc_load_val = pc + off_q;
                    taken_next  = 1'b1;
                end
                done_next  = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Registered one-cycle strobes, link value and latched branch offset.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            off_q     <= 32'd0;
            con_load  <= 1'b0;
            link_we   <= 1'b0;
            link_data <= 32'd0;
            done      <= 1'b0;
            taken     <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            off_q     <= off_next;
            con_load  <= con_load_next;
            link_we   <= link_we_next;
            link_data <= link_data_next;
            done      <= done_next;
            taken     <= taken_next;
            illegal   <= illegal_next;
        end
    end

endmodule
